// File: rtl/slice_sequencer.sv
// slice_sequencer
//   Takes packed words over a valid/ready handshake. Each word is split into
//   an upper field (word[DATA_W-1:LO_W]) and a lower field (word[LO_W-1:0]).
//   The two fields go out one at a time on a shared output lane. Each field
//   is tagged with its field id, and the second field of a word is flagged
//   as last. Only one word is in flight at a time.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   block can accept a word (IDLE only)
//   in_data    packed word, DATA_W bits
//   in_lo_1st  1: emit lower field first (sampled with the word)
//   out_valid  field valid on out_data
//   out_ready  consumer accepts field
//   out_data   field, HI_W bits; lower field is zero-extended
//   out_tag    0 = upper field, 1 = lower field
//   out_last   field is the second (final) field of its word
//   word_done  one-cycle pulse after the final field handshake
//   word_cnt   completed-word counter, wraps silently
module slice_sequencer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LO_W   = 3,
   parameter int unsigned CNT_W  = 8,
   localparam int unsigned HI_W  = DATA_W - LO_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_lo_1st,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [HI_W-1:0]   out_data,
   output logic              out_tag,
   output logic              out_last,
   output logic              word_done,
   output logic [CNT_W-1:0]  word_cnt
);

   generate
      if (!(LO_W < DATA_W) || !(LO_W <= HI_W)) begin : g_param_check
         $error("slice_sequencer: requires LO_W < DATA_W and LO_W <= DATA_W-LO_W");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] word_q;
   logic              lo_1st_q;
   logic              accept, fire_first, fire_second;
   logic [HI_W-1:0]   in_hi, in_lo, q_hi, q_lo;

   // Field views of the incoming word and of the latched word.
   // The width cast zero-extends the lower field to the lane width.
   assign in_hi = in_data[DATA_W-1:LO_W];
   assign in_lo = HI_W'(in_data[LO_W-1:0]);
   assign q_hi  = word_q[DATA_W-1:LO_W];
   assign q_lo  = HI_W'(word_q[LO_W-1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      accept      = 1'b0;
      fire_first  = 1'b0;
      fire_second = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) state_d = FIRST;
         end
         FIRST: begin
            out_valid  = 1'b1;
            fire_first = out_ready;
            if (out_ready) state_d = SECOND;
         end
         SECOND: begin
            out_valid   = 1'b1;
            fire_second = out_ready;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The output fields are registered. The first field is loaded straight
   // from in_data on the accept edge, so it is valid in the cycle after the
   // accept. The second field is loaded from the latched word on the
   // first-field handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q    <= '0;
         lo_1st_q  <= 1'b0;
         out_data  <= '0;
         out_tag   <= 1'b0;
         out_last  <= 1'b0;
         word_done <= 1'b0;
         word_cnt  <= '0;
      end else begin
         word_done <= 1'b0;
         if (accept) begin
            word_q   <= in_data;
            lo_1st_q <= in_lo_1st;
            out_data <= in_lo_1st ? in_lo : in_hi;
            out_tag  <= in_lo_1st;
            out_last <= 1'b0;
         end else if (fire_first) begin
            out_data <= lo_1st_q ? q_hi : q_lo;
            out_tag  <= ~lo_1st_q;
            out_last <= 1'b1;
         end else if (fire_second) begin
            word_done <= 1'b1;
            word_cnt  <= word_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_slice_sequencer.sv
// Self-checking bench for slice_sequencer (default parameters: 8/3/8).
module tb_slice_sequencer;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_lo_1st;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_data;
   logic       out_tag;
   logic       out_last;
   logic       word_done;
   logic [7:0] word_cnt;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_cnt = '0;

   slice_sequencer #(.DATA_W(8), .LO_W(3), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_lo_1st (in_lo_1st),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_last  (out_last),
      .word_done (word_done),
      .word_cnt  (word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       lo1;
      logic [4:0] f1;
      logic       t1;
      logic [4:0] f2;
      logic       t2;
   } vec_t;

   typedef struct {
      logic [4:0] d;
      logic       tag;
      logic       last;
   } fld_t;

   vec_t vecs[6];
   fld_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_out_data"},  {27'd0, out_data},  32'd0);
      chk({tag, "_out_tag"},   {31'd0, out_tag},   32'd0);
      chk({tag, "_out_last"},  {31'd0, out_last},  32'd0);
      chk({tag, "_word_done"}, {31'd0, word_done}, 32'd0);
      chk({tag, "_word_cnt"},  {24'd0, word_cnt},  32'd0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_values(tag);
      @(negedge clk);
      rst_n   = 1'b1;
      exp_cnt = '0;
      tick();
   endtask

   // Streams n words through the DUT against a field scoreboard. With rnd=0
   // the input is always valid and out_ready stays high, so accepts must be
   // exactly 3 cycles apart.
   task automatic stream(input int n, input bit rnd, input string tag);
      int   sent = 0;
      int   got = 0;
      int   cyc = 0;
      int   last_acc = -1;
      bit   done_exp = 1'b0;
      fld_t e;
      while ((sent < n || got < 2 * n) && cyc < 8000) begin
         in_valid  = (sent < n) ? (rnd ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b0;
         in_data   = 8'($urandom);
         in_lo_1st = 1'($urandom_range(0, 1));
         out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (word_done !== done_exp)
            chk({tag, "_word_done"}, {31'd0, word_done}, {31'd0, done_exp});
         done_exp = 1'b0;
         if (in_valid && in_ready) begin
            e.d = in_data[7:3];            e.tag = 1'b0; e.last = 1'b0;
            if (in_lo_1st) begin e.d = {2'b00, in_data[2:0]}; e.tag = 1'b1; end
            exp_q.push_back(e);
            e.last = 1'b1;
            if (in_lo_1st) begin e.d = in_data[7:3]; e.tag = 1'b0; end
            else begin e.d = {2'b00, in_data[2:0]}; e.tag = 1'b1; end
            exp_q.push_back(e);
            if (!rnd && last_acc >= 0) chk({tag, "_accept_spacing"}, cyc - last_acc, 32'd3);
            last_acc = cyc;
            sent++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk({tag, "_unexpected_field"}, {27'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e.d || out_tag !== e.tag || out_last !== e.last)
                  chk({tag, "_field"}, {23'd0, out_data, 2'b00, out_tag, out_last},
                      {23'd0, e.d, 2'b00, e.tag, e.last});
               else
                  checks++;
               if (e.last) begin
                  done_exp = 1'b1;
                  exp_cnt  = exp_cnt + 8'd1;
               end
            end
            got++;
         end
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk({tag, "_fields_received"}, got, 2 * n);
      chk({tag, "_last_word_done"}, {31'd0, word_done}, {31'd0, done_exp});
      chk({tag, "_word_cnt"}, {24'd0, word_cnt}, {24'd0, exp_cnt});
      chk({tag, "_scoreboard_empty"}, exp_q.size(), 32'd0);
      tick();
   endtask

   initial begin
      vecs[0] = '{data: 8'b11010001, lo1: 1'b0, f1: 5'b11010, t1: 1'b0, f2: 5'b00001, t2: 1'b1};
      vecs[1] = '{data: 8'b00110101, lo1: 1'b1, f1: 5'b00101, t1: 1'b1, f2: 5'b00110, t2: 1'b0};
      vecs[2] = '{data: 8'b11111111, lo1: 1'b0, f1: 5'b11111, t1: 1'b0, f2: 5'b00111, t2: 1'b1};
      vecs[3] = '{data: 8'b00000000, lo1: 1'b1, f1: 5'b00000, t1: 1'b1, f2: 5'b00000, t2: 1'b0};
      vecs[4] = '{data: 8'b10001100, lo1: 1'b0, f1: 5'b10001, t1: 1'b0, f2: 5'b00100, t2: 1'b1};
      vecs[5] = '{data: 8'b01111010, lo1: 1'b1, f1: 5'b00010, t1: 1'b1, f2: 5'b01111, t2: 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_lo_1st = 1'b0;
      out_ready = 1'b1;
      #12;
      check_reset_values("por");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Table-driven single words with out_ready held high.
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("v%0d_in_ready_idle", i), {31'd0, in_ready}, 32'd1);
         chk($sformatf("v%0d_out_valid_idle", i), {31'd0, out_valid}, 32'd0);
         in_valid  = 1'b1;
         in_data   = vecs[i].data;
         in_lo_1st = vecs[i].lo1;
         tick();
         in_valid  = 1'b0;
         in_data   = 8'hA5;
         in_lo_1st = ~vecs[i].lo1;
         chk($sformatf("v%0d_f1_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("v%0d_f1_in_ready", i), {31'd0, in_ready}, 32'd0);
         chk($sformatf("v%0d_f1_data", i), {27'd0, out_data}, {27'd0, vecs[i].f1});
         chk($sformatf("v%0d_f1_tag", i), {31'd0, out_tag}, {31'd0, vecs[i].t1});
         chk($sformatf("v%0d_f1_last", i), {31'd0, out_last}, 32'd0);
         tick();
         chk($sformatf("v%0d_f2_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("v%0d_f2_data", i), {27'd0, out_data}, {27'd0, vecs[i].f2});
         chk($sformatf("v%0d_f2_tag", i), {31'd0, out_tag}, {31'd0, vecs[i].t2});
         chk($sformatf("v%0d_f2_last", i), {31'd0, out_last}, 32'd1);
         chk($sformatf("v%0d_no_done_early", i), {31'd0, word_done}, 32'd0);
         tick();
         exp_cnt = exp_cnt + 8'd1;
         chk($sformatf("v%0d_word_done", i), {31'd0, word_done}, 32'd1);
         chk($sformatf("v%0d_word_cnt", i), {24'd0, word_cnt}, {24'd0, exp_cnt});
         chk($sformatf("v%0d_idle_valid", i), {31'd0, out_valid}, 32'd0);
         chk($sformatf("v%0d_hold_data", i), {27'd0, out_data}, {27'd0, vecs[i].f2});
         tick();
         chk($sformatf("v%0d_done_single", i), {31'd0, word_done}, 32'd0);
      end

      // Backpressure: first field held for 4 stalled cycles, second for 2.
      in_valid  = 1'b1;
      in_data   = 8'b10001100;
      in_lo_1st = 1'b0;
      out_ready = 1'b0;
      tick();
      in_data = 8'hFF;
      in_lo_1st = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("stall%0d_data", k), {27'd0, out_data}, 32'b10001);
         chk($sformatf("stall%0d_tag_last", k), {30'd0, out_tag, out_last}, 32'd0);
         chk($sformatf("stall%0d_valid", k), {31'd0, out_valid}, 32'd1);
         chk($sformatf("stall%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("stall2_%0d_data", k), {27'd0, out_data}, 32'b00100);
         chk($sformatf("stall2_%0d_tag_last", k), {30'd0, out_tag, out_last}, 32'd3);
         chk($sformatf("stall2_%0d_no_done", k), {31'd0, word_done}, 32'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      exp_cnt = exp_cnt + 8'd1;
      chk("stall_word_done", {31'd0, word_done}, 32'd1);
      chk("stall_word_cnt", {24'd0, word_cnt}, {24'd0, exp_cnt});
      tick();

      // Reset while the second field is pending.
      in_valid  = 1'b1;
      in_data   = 8'b11010001;
      in_lo_1st = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      chk("pre_rst_in_second", {31'd0, out_last}, 32'd1);
      do_reset("midword");
      out_ready = 1'b1;
      chk("midword_no_done", {31'd0, word_done}, 32'd0);
      chk("midword_idle", {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_data   = 8'b00110101;
      in_lo_1st = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("post_rst_f1", {25'd0, out_data, out_tag, out_last}, {25'd0, 5'b00101, 2'b10});
      tick();
      chk("post_rst_f2", {25'd0, out_data, out_tag, out_last}, {25'd0, 5'b00110, 2'b01});
      tick();
      chk("post_rst_word_cnt", {24'd0, word_cnt}, 32'd1);
      tick();

      // Back-to-back words with in_valid held high.
      do_reset("pre_b2b");
      stream(3, 1'b0, "b2b");
      chk("b2b_word_cnt_3", {24'd0, word_cnt}, 32'd3);

      // 256 words with random stalls: counter wraps back to 0.
      do_reset("pre_wrap");
      stream(256, 1'b1, "wrap");
      chk("wrap_word_cnt_0", {24'd0, word_cnt}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
